// File: rtl/pc_update_pkg.sv
// Shared Y86-64 icode and status encodings plus the PC unit state type.
package pc_update_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;

  typedef enum logic [1:0] {RUN, HALTED, FAULT} state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux for every Y86-64 icode, flagging illegal icodes
// and targets above PC_MAX.
module pc_next_sel #(
  parameter int unsigned         ADDR_W = 64,
  parameter logic [ADDR_W-1:0]   PC_MAX = ADDR_W'(65535)
) (
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] valC,
  input  logic [ADDR_W-1:0] valM,
  input  logic [ADDR_W-1:0] valP,
  output logic [ADDR_W-1:0] next_pc,
  output logic              illegal,
  output logic              oob
);
  import pc_update_pkg::*;

  always_comb begin
    next_pc = pc;
    illegal = 1'b0;
    case (icode)
      I_HALT:  next_pc = pc;
      I_JXX:   next_pc = cnd ? valC : valP;
      I_CALL:  next_pc = valC;
      I_RET:   next_pc = valM;
      I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ,
      I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:
               next_pc = valP;
      default: illegal = 1'b1;
    endcase
  end

  // Halt keeps the current pc, so only real control flow can go out of range.
  assign oob = (icode != I_HALT) && !illegal && (next_pc > PC_MAX);

endmodule

// File: rtl/pc_update_unit.sv
// Y86-64 PC register with update handshake, debugger load and status FSM.
// Optional performance counters are built when PC_PERF_CNT_EN is defined.
module pc_update_unit #(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_MAX   = ADDR_W'(65535),
  parameter int unsigned       CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [ADDR_W-1:0] valC,
  input  logic [ADDR_W-1:0] valM,
  input  logic [ADDR_W-1:0] valP,
  input  logic              imem_error,
  input  logic              dmem_error,
  input  logic              stall,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        stat,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);
  import pc_update_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        stat_q, stat_d;
  logic [ADDR_W-1:0] next_pc;
  logic              illegal, oob, accept, fault;

  pc_next_sel #(.ADDR_W(ADDR_W), .PC_MAX(PC_MAX)) u_next_sel (
    .icode   (icode),
    .cnd     (cnd),
    .pc      (pc_q),
    .valC    (valC),
    .valM    (valM),
    .valP    (valP),
    .next_pc (next_pc),
    .illegal (illegal),
    .oob     (oob)
  );

  assign upd_ready = (state_q == RUN) && !stall && !load_en;
  assign accept    = upd_valid && upd_ready;
  assign fault     = imem_error || dmem_error || illegal || oob;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    if (load_en) begin
      pc_d    = load_pc;
      state_d = (load_pc > PC_MAX) ? FAULT : RUN;
      stat_d  = (load_pc > PC_MAX) ? ADR : AOK;
    end else if (accept) begin
      if (fault) begin
        // Memory errors outrank the illegal-icode report.
        state_d = FAULT;
        stat_d  = (illegal && !imem_error && !dmem_error) ? INS : ADR;
      end else if (icode == I_HALT) begin
        state_d = HALTED;
        stat_d  = HLT;
      end else begin
        pc_d = next_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      stat_q  <= AOK;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
    end
  end

  assign pc   = pc_q;
  assign stat = stat_q;

`ifdef PC_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d, taken_q, taken_d;
  logic             retire, taken;

  assign retire = accept && !fault;
  assign taken  = retire && (((icode == I_JXX) && cnd) || (icode == I_CALL) || (icode == I_RET));

  always_comb begin
    retired_d = retired_q;
    taken_d   = taken_q;
    if (load_en) begin
      retired_d = '0;
      taken_d   = '0;
    end else begin
      if (retire && (retired_q != '1)) retired_d = retired_q + CNT_W'(1);
      if (taken && (taken_q != '1))    taken_d   = taken_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else begin
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  assign retired_cnt = retired_q;
  assign taken_cnt   = taken_q;
`else
  assign retired_cnt = '0;
  assign taken_cnt   = '0;
`endif

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit; a monitor checks pc/stat/counters after
// every accepted update or debugger load against a queue of expected results.
module tb_pc_update_unit;
  import pc_update_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0, upd_ready;
  logic [3:0]  icode = 4'h1;
  logic        cnd = 1'b0;
  logic [63:0] valC = '0, valM = '0, valP = '0, load_pc = '0;
  logic        imem_error = 1'b0, dmem_error = 1'b0, stall = 1'b0, load_en = 1'b0;
  logic [63:0] pc;
  logic [2:0]  stat;
  logic [31:0] retired_cnt, taken_cnt;

  typedef struct {
    logic [63:0] pc;
    logic [2:0]  stat;
    int          r;
    int          t;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  pc_update_unit dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .icode(icode), .cnd(cnd), .valC(valC), .valM(valM), .valP(valP),
    .imem_error(imem_error), .dmem_error(dmem_error), .stall(stall),
    .load_en(load_en), .load_pc(load_pc), .pc(pc), .stat(stat),
    .retired_cnt(retired_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] cx(input int v);
`ifdef PC_PERF_CNT_EN
    return 64'(v);
`else
    return (v == v) ? 64'd0 : 64'd1;
`endif
  endfunction

  // Monitor: an event is any accepted update or load at a rising edge;
  // its result is checked on the following falling edge.
  initial begin
    logic acc;
    exp_t e;
    forever begin
      @(posedge clk);
      acc = !rst && (load_en || (upd_valid && upd_ready));
      @(negedge clk);
      if (acc) begin
        if (sb.size() == 0) begin
          check("unexpected_event", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("pc", pc, e.pc);
          check("stat", 64'(stat), 64'(e.stat));
          check("retired_cnt", 64'(retired_cnt), cx(e.r));
          check("taken_cnt", 64'(taken_cnt), cx(e.t));
        end
      end
    end
  end

  task automatic upd(input logic [3:0] ic, input logic c, input logic [63:0] vc,
                     input logic [63:0] vm, input logic [63:0] vp,
                     input logic ie, input logic de, input logic [63:0] epc,
                     input logic [2:0] est, input int er, input int et);
    int guard = 0;
    icode = ic; cnd = c; valC = vc; valM = vm; valP = vp;
    imem_error = ie; dmem_error = de;
    sb.push_back('{epc, est, er, et});
    upd_valid = 1'b1;
    while (!upd_ready && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!upd_ready) begin
      check("upd_ready_timeout", 64'(upd_ready), 64'd1);
      void'(sb.pop_back());
      upd_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      upd_valid = 1'b0;
    end
    imem_error = 1'b0; dmem_error = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic load(input logic [63:0] v, input logic [2:0] est);
    sb.push_back('{v, est, 0, 0});
    load_pc = v;
    load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("reset_pc", pc, 64'h0);
    check("reset_stat", 64'(stat), 64'(AOK));
    check("reset_ready", 64'(upd_ready), 64'd1);
    rst = 1'b0;

    upd(I_OPQ,  1'b0, 64'h0,   64'h0,  64'h0A, 1'b0, 1'b0, 64'h0A,  AOK, 1, 0);
    upd(I_JXX,  1'b1, 64'h40,  64'h0,  64'h12, 1'b0, 1'b0, 64'h40,  AOK, 2, 1);
    upd(I_JXX,  1'b0, 64'h40,  64'h0,  64'h12, 1'b0, 1'b0, 64'h12,  AOK, 3, 1);
    upd(I_CALL, 1'b0, 64'h100, 64'h0,  64'h1B, 1'b0, 1'b0, 64'h100, AOK, 4, 2);
    upd(I_RET,  1'b0, 64'h0,   64'h1B, 64'h0,  1'b0, 1'b0, 64'h1B,  AOK, 5, 3);

    // Stalled update must not be taken, then goes in on the first free edge.
    icode = I_NOP; valP = 64'h30; stall = 1'b1; upd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk); #1;
      check("stall_pc", pc, 64'h1B);
      check("stall_ready", 64'(upd_ready), 64'd0);
    end
    sb.push_back('{64'h30, AOK, 6, 3});
    stall = 1'b0;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    @(negedge clk); #1;

    upd(I_HALT, 1'b0, 64'h0, 64'h0, 64'h55, 1'b0, 1'b0, 64'h30, HLT, 7, 3);
    check("halt_ready", 64'(upd_ready), 64'd0);
    icode = I_OPQ; valP = 64'h44; upd_valid = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    #1;
    upd_valid = 1'b0;
    check("halted_pc_hold", pc, 64'h30);
    check("halted_stat_hold", 64'(stat), 64'(HLT));

    load(64'h20, AOK);
    check("load_ready", 64'(upd_ready), 64'd1);

    upd(I_CALL, 1'b0, 64'h10000, 64'h0, 64'h0, 1'b0, 1'b0, 64'h20, ADR, 0, 0);
    load(64'h40, AOK);
    upd(4'hD, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h40, INS, 0, 0);
    load(64'h50, AOK);
    upd(4'hD, 1'b0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h50, ADR, 0, 0);
    load(64'h50, AOK);
    upd(I_OPQ, 1'b0, 64'h0, 64'h0, 64'h60, 1'b0, 1'b1, 64'h50, ADR, 0, 0);
    load(64'h10000, ADR);
    load(64'h8, AOK);
    upd(I_IRMOVQ, 1'b0, 64'h0, 64'h0, 64'hFFFF, 1'b0, 1'b0, 64'hFFFF, AOK, 1, 0);
    upd(I_RET, 1'b0, 64'h0, 64'h10000, 64'h0, 1'b0, 1'b0, 64'hFFFF, ADR, 1, 0);

    // Load wins over an update presented in the same cycle.
    load(64'h8, AOK);
    sb.push_back('{64'h70, AOK, 0, 0});
    icode = I_OPQ; valP = 64'h90; upd_valid = 1'b1;
    load_pc = 64'h70; load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0; upd_valid = 1'b0;
    @(negedge clk); #1;

    // Asynchronous reset in the middle of a presented update.
    upd_valid = 1'b1; icode = I_OPQ; valP = 64'h99;
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc", pc, 64'h0);
    check("async_rst_stat", 64'(stat), 64'(AOK));
    check("async_rst_retired", 64'(retired_cnt), 64'd0);
    @(negedge clk); #1;
    upd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;
    check("post_rst_pc", pc, 64'h0);
    check("post_rst_ready", 64'(upd_ready), 64'd1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    check("global_timeout", 64'd1, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
